// File: rtl/fifo_wt_arbiter.sv
// Round-robin arbiter sharing the single FIFO push port among num_req producers.
// Grants bounded bursts and uses full/almost-full so a push never lands on a full FIFO.
module fifo_wt_arbiter #(
    parameter int data_width = 4,
    parameter int num_req    = 4,
    parameter int burst_max  = 4
) (
    input  logic                          wt_clk_arb,
    input  logic                          rst_in_arb,
    input  logic [num_req-1:0]            req_arb,
    input  logic [num_req*data_width-1:0] data_in_arb,
    input  logic                          full_st_arb,
    input  logic                          almost_full_arb,
    output logic [num_req-1:0]            gnt_arb,
    output logic                          wt_en_arb,
    output logic [data_width-1:0]         data_out_arb,
    output logic [2:0]                    owner_arb,
    output logic [1:0]                    state_arb,
    output logic [15:0]                   push_cnt_arb
);
    localparam int         IW         = $clog2(num_req);
    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_BURST   = 2'b01;
    localparam logic [1:0] ST_STALL   = 2'b10;
    localparam logic [3:0] BURST_LAST = 4'(burst_max - 1);

    // Returns {found, index} of the first request after ptr, wrapping; ptr itself is checked last.
    function automatic logic [IW:0] rr_pick(input logic [num_req-1:0] req, input logic [IW-1:0] ptr);
        logic [IW:0]   res;
        logic [IW-1:0] idx;
        res = {(IW+1){1'b0}};
        for (int i = num_req; i >= 1; i--) begin
            idx = IW'((int'(ptr) + i) % num_req);
            if (req[idx]) begin
                res = {1'b1, idx};
            end else begin
                res = res;
            end
        end
        return res;
    endfunction

    logic [1:0]         state_r, state_nxt_s;
    logic [num_req-1:0] gnt_r, gnt_nxt_s, pick_gnt_s;
    logic [IW-1:0]      owner_r, owner_nxt_s, ptr_r, ptr_nxt_s, pick_idx_s;
    logic [3:0]         bcnt_r, bcnt_nxt_s;
    logic [15:0]        push_cnt_r;
    logic [IW:0]        pick_s;
    logic               pick_found_s, release_s, wt_en_s;

    assign pick_s       = rr_pick(req_arb, ptr_r);
    assign pick_found_s = pick_s[IW];
    assign pick_idx_s   = pick_s[IW-1:0];
    assign pick_gnt_s   = {{(num_req-1){1'b0}}, 1'b1} << pick_idx_s;
    assign wt_en_s      = (state_r == ST_BURST) && req_arb[owner_r] && !full_st_arb;

    // Push data mux: only the owner's slice, and only while pushing.
    always_comb begin
        if (wt_en_s) begin
            data_out_arb = data_in_arb[int'(owner_r)*data_width +: data_width];
        end else begin
            data_out_arb = {data_width{1'b0}};
        end
    end

    // Next-state logic; IDLE entry is treated like a release so both share the grant path.
    always_comb begin
        state_nxt_s = state_r;
        gnt_nxt_s   = gnt_r;
        owner_nxt_s = owner_r;
        ptr_nxt_s   = ptr_r;
        bcnt_nxt_s  = bcnt_r;
        release_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (!full_st_arb) begin
                    release_s = 1'b1;
                end else begin
                    gnt_nxt_s = {num_req{1'b0}};
                end
            end
            ST_BURST: begin
                if (full_st_arb) begin
                    state_nxt_s = ST_STALL;
                end else if (wt_en_s && ((bcnt_r == BURST_LAST) || almost_full_arb)) begin
                    release_s = 1'b1;
                end else if (!req_arb[owner_r]) begin
                    release_s = 1'b1;
                end else begin
                    bcnt_nxt_s = bcnt_r + 4'd1;
                end
            end
            ST_STALL: begin
                if (full_st_arb) begin
                    state_nxt_s = ST_STALL;
                end else if (req_arb[owner_r]) begin
                    state_nxt_s = ST_BURST;
                end else begin
                    release_s = 1'b1;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {num_req{1'b0}};
                bcnt_nxt_s  = 4'd0;
            end
        endcase
        // The pointer sits on the owner, so a plain search naturally prefers others over a re-grant.
        case ({release_s, pick_found_s})
            2'b11: begin
                state_nxt_s = ST_BURST;
                gnt_nxt_s   = pick_gnt_s;
                owner_nxt_s = pick_idx_s;
                ptr_nxt_s   = pick_idx_s;
                bcnt_nxt_s  = 4'd0;
            end
            2'b10: begin
                state_nxt_s = ST_IDLE;
                gnt_nxt_s   = {num_req{1'b0}};
                bcnt_nxt_s  = 4'd0;
            end
            default: begin
            end
        endcase
    end

    // Arbitration state and push counter registers.
    always_ff @(posedge wt_clk_arb or posedge rst_in_arb) begin
        if (rst_in_arb) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {num_req{1'b0}};
            owner_r    <= {IW{1'b0}};
            ptr_r      <= IW'(num_req - 1);
            bcnt_r     <= 4'd0;
            push_cnt_r <= 16'd0;
        end else begin
            state_r <= state_nxt_s;
            gnt_r   <= gnt_nxt_s;
            owner_r <= owner_nxt_s;
            ptr_r   <= ptr_nxt_s;
            bcnt_r  <= bcnt_nxt_s;
            if (wt_en_s) begin
                push_cnt_r <= push_cnt_r + 16'd1;
            end else begin
                push_cnt_r <= push_cnt_r;
            end
        end
    end

    assign gnt_arb      = gnt_r;
    assign wt_en_arb    = wt_en_s;
    assign owner_arb    = 3'(owner_r);
    assign state_arb    = state_r;
    assign push_cnt_arb = push_cnt_r;
endmodule

// File: tb/tb_fifo_wt_arbiter.sv
// Scoreboard bench for fifo_wt_arbiter: random producers and a modelled FIFO,
// checked against a rule-level reference of the round-robin burst arbiter.
`timescale 1ns/1ps
module tb_fifo_wt_arbiter;
    localparam int DW    = 4;
    localparam int NR    = 4;
    localparam int BM    = 4;
    localparam int DEPTH = 6;

    logic             clk = 1'b0;
    logic             rst;
    logic [NR-1:0]    req;
    logic [NR*DW-1:0] data_in;
    logic             full, af;
    logic [NR-1:0]    gnt;
    logic             wt_en;
    logic [DW-1:0]    data_out;
    logic [2:0]       owner;
    logic [1:0]       state;
    logic [15:0]      push_cnt;

    always #5 clk = ~clk;

    fifo_wt_arbiter #(.data_width(DW), .num_req(NR), .burst_max(BM)) dut (
        .wt_clk_arb(clk), .rst_in_arb(rst), .req_arb(req), .data_in_arb(data_in),
        .full_st_arb(full), .almost_full_arb(af), .gnt_arb(gnt), .wt_en_arb(wt_en),
        .data_out_arb(data_out), .owner_arb(owner), .state_arb(state), .push_cnt_arb(push_cnt)
    );

    typedef struct { logic [NR-1:0] gnt; logic [1:0] st; logic wt_en; logic [15:0] cnt; logic [2:0] own; } cyc_t;
    typedef struct { logic [2:0] own; logic [DW-1:0] dat; } push_t;

    cyc_t  cyc_q[$];
    push_t push_q[$];
    int    owner_log[$];
    int    n_cmp = 0;
    int    n_fail = 0;
    bit    mon_en = 1'b0;

    // reference model: 0 idle, 1 burst, 2 stall
    int m_state, m_owner, m_ptr, m_cnt, m_pushes;
    bit m_valid;
    int rem[NR];
    int occ;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int pick(input logic [NR-1:0] r, input int p);
        for (int d = 1; d <= NR; d++) begin
            if (r[(p + d) % NR]) return (p + d) % NR;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_state = 0; m_owner = 0; m_ptr = NR - 1; m_cnt = 0; m_pushes = 0; m_valid = 1'b0;
        occ = 0;
    endtask

    task automatic model_grant(input int w);
        m_state = 1; m_owner = w; m_ptr = w; m_cnt = 0; m_valid = 1'b1;
    endtask

    // One cycle: drive inputs, queue expectations, advance model, wait for the edge.
    task automatic step(input bit all_req);
        logic [NR-1:0]    r;
        logic [NR*DW-1:0] d;
        bit f, a, push, rel, pop;
        int w;
        cyc_t  c;
        push_t p;
        for (int i = 0; i < NR; i++) begin
            if (all_req) begin
                r[i] = 1'b1;
            end else begin
                if (rem[i] == 0 && $urandom_range(0, 7) == 0) rem[i] = int'($urandom_range(1, 9));
                r[i] = (rem[i] > 0) && ($urandom_range(0, 29) != 0);
            end
            d[i*DW +: DW] = DW'($urandom);
        end
        f = (occ >= DEPTH);
        a = (occ == DEPTH - 1);
        req = r; data_in = d; full = f; af = a;

        push = (m_state == 1) && r[m_owner] && !f;
        c.gnt = '0;
        if (m_valid) c.gnt[m_owner] = 1'b1;
        c.st = m_state[1:0]; c.wt_en = push; c.cnt = m_pushes[15:0]; c.own = m_owner[2:0];
        cyc_q.push_back(c);
        if (push) begin
            p.own = m_owner[2:0]; p.dat = d[m_owner*DW +: DW];
            push_q.push_back(p);
            m_pushes++;
            if (!all_req) rem[m_owner]--;
        end

        rel = 1'b0;
        case (m_state)
            0: begin
                w = pick(r, m_ptr);
                if (w >= 0 && !f) model_grant(w);
            end
            1: begin
                if (f) m_state = 2;
                else if (push && (m_cnt + 1 == BM || a)) rel = 1'b1;
                else if (!r[m_owner]) rel = 1'b1;
                else m_cnt++;
            end
            2: begin
                if (!f) begin
                    if (r[m_owner]) m_state = 1;
                    else rel = 1'b1;
                end
            end
            default: ;
        endcase
        if (rel) begin
            w = pick(r, m_ptr);
            if (w >= 0) model_grant(w);
            else begin m_state = 0; m_valid = 1'b0; m_cnt = 0; end
        end

        pop = all_req ? 1'b1 : ($urandom_range(0, 2) == 0);
        occ = occ + (push ? 1 : 0) - ((pop && occ > 0) ? 1 : 0);
        @(posedge clk); #1;
    endtask

    cyc_t  mc;
    push_t mp;

    // Monitor: pops the expected cycle record and, on a push, the expected push.
    always @(negedge clk) begin
        if (mon_en && !rst) begin
            if (cyc_q.size() == 0) begin
                n_cmp++; n_fail++;
                $display("FAIL record_avail: got 0, expected 1 (t=%0t)", $time);
            end else begin
                mc = cyc_q.pop_front();
                chk("gnt", 32'(gnt), 32'(mc.gnt));
                chk("state", 32'(state), 32'(mc.st));
                chk("wt_en", 32'(wt_en), 32'(mc.wt_en));
                chk("push_cnt", 32'(push_cnt), 32'(mc.cnt));
                if (mc.gnt != '0) chk("owner", 32'(owner), 32'(mc.own));
                if (mc.wt_en) mp = push_q.pop_front();
                if (wt_en) owner_log.push_back(int'(owner));
                if (wt_en && mc.wt_en) begin
                    chk("push_data", 32'(data_out), 32'(mp.dat));
                    chk("push_owner", 32'(owner), 32'(mp.own));
                end else if (!wt_en) begin
                    chk("idle_data", 32'(data_out), 32'd0);
                end
            end
        end
    end

    initial begin
        rst = 1'b1; req = '0; data_in = '0; full = 1'b0; af = 1'b0;
        model_reset();
        for (int i = 0; i < NR; i++) rem[i] = 0;
        repeat (2) @(posedge clk);
        #1; req = '1; data_in = 16'hA5C3;
        #1;
        chk("rst_gnt", 32'(gnt), 32'd0);
        chk("rst_wt_en", 32'(wt_en), 32'd0);
        chk("rst_state", 32'(state), 32'd0);
        chk("rst_owner", 32'(owner), 32'd0);
        chk("rst_push_cnt", 32'(push_cnt), 32'd0);
        chk("rst_data_out", 32'(data_out), 32'd0);
        rst = 1'b0;
        mon_en = 1'b1;

        // fairness: all four requesting, FIFO drained each cycle
        owner_log.delete();
        repeat (30) step(1'b1);
        chk("fair_len", 32'(owner_log.size() >= 20), 32'd1);
        for (int k = 0; k < 20 && k < owner_log.size(); k++)
            chk("fair_owner", 32'(owner_log[k]), 32'((k / BM) % NR));

        // random producers, drops, full/almost-full from a modelled FIFO
        repeat (3000) step(1'b0);

        // reset in the middle of a burst
        for (int k = 0; k < 50 && m_state != 1; k++) step(1'b1);
        step(1'b1);
        mon_en = 1'b0;
        #2; rst = 1'b1;
        #1;
        chk("midrst_gnt", 32'(gnt), 32'd0);
        chk("midrst_wt_en", 32'(wt_en), 32'd0);
        chk("midrst_push_cnt", 32'(push_cnt), 32'd0);
        chk("midrst_state", 32'(state), 32'd0);
        cyc_q.delete(); push_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
        model_reset();
        mon_en = 1'b1;
        step(1'b1);
        chk("post_rst_gnt", 32'(gnt), 32'h1);
        repeat (20) step(1'b1);
        mon_en = 1'b0;
        chk("push_q_drained", 32'(push_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
